guvm_modport: RTL and testbench



---
 rtl/guvm_modport.sv | 150 +++++++++++++++
 tb/tb_guvm_modport.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/guvm_modport.sv
// Memory-side adapter between the GUVM driver/monitor and the RISC-V core:
// instruction holding register, small data word memory, store monitor taps and static core controls.
module guvm_modport #(
    parameter int unsigned INSTR_RDATA_WIDTH = 32,
    parameter logic [31:0] BOOT_ADDR         = 32'h0000000A,
    parameter int unsigned MEM_WORDS         = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic [INSTR_RDATA_WIDTH-1:0] inst_in_i,
    input  logic                         inst_valid_i,
    output logic                         inst_ready_o,

    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,

    input  logic                         data_req_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic [31:0]                  data_rdata_o,

    output logic [31:0]                  wdata_o,
    output logic [31:0]                  waddr_o,
    output logic [3:0]                   wbe_o,
    output logic                         wdata_valid_o,

    output logic [31:0]                  boot_addr_o,
    output logic [3:0]                   core_id_o,
    output logic [5:0]                   cluster_id_o,
    output logic                         clock_en_o,
    output logic                         test_en_o,
    output logic                         irq_o,
    output logic                         debug_req_o,
    output logic                         fetch_enable_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    // Instruction holding register
    logic                         full;
    logic [INSTR_RDATA_WIDTH-1:0] hold_q;
    logic                         inst_load;

    assign instr_gnt_o  = instr_req_i & full;
    assign inst_ready_o = ~full | instr_gnt_o;
    assign inst_load    = inst_valid_i & inst_ready_o;

    // A grant and a load in the same cycle hand the old word out and keep the new one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full           <= 1'b0;
            hold_q         <= '0;
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
        end else begin
            instr_rvalid_o <= instr_gnt_o;
            if (instr_gnt_o) begin
                instr_rdata_o <= hold_q;
            end
            if (inst_load) begin
                hold_q <= inst_in_i;
                full   <= 1'b1;
            end else if (instr_gnt_o) begin
                full <= 1'b0;
            end
        end
    end

    // Data memory; upper address bits alias onto the same words
    logic [31:0]   mem_q [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic          store;

    assign word_idx   = data_addr_i[AW+1:2];
    assign data_gnt_o = data_req_i;
    assign store      = data_req_i & data_we_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else if (store) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Load data is the pre-store word value; stores also answer with rvalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            data_rvalid_o <= data_req_i;
            if (data_req_i && !data_we_i) begin
                data_rdata_o <= mem_q[word_idx];
            end
        end
    end

    // Store monitor taps hold until the next store
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdata_o       <= '0;
            waddr_o       <= '0;
            wbe_o         <= '0;
            wdata_valid_o <= 1'b0;
        end else begin
            wdata_valid_o <= store;
            if (store) begin
                wdata_o <= data_wdata_i;
                waddr_o <= data_addr_i;
                wbe_o   <= data_be_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_enable_o <= 1'b0;
        end else begin
            fetch_enable_o <= 1'b1;
        end
    end

    assign boot_addr_o  = BOOT_ADDR;
    assign core_id_o    = '0;
    assign cluster_id_o = '0;
    assign clock_en_o   = 1'b1;
    assign test_en_o    = 1'b0;
    assign irq_o        = 1'b0;
    assign debug_req_o  = 1'b0;

    // Fetch address is intentionally not decoded
    logic unused_instr_addr;
    assign unused_instr_addr = ^instr_addr_i;

endmodule

// File: tb/tb_guvm_modport.sv
// Randomized scoreboard bench for guvm_modport against a queue/array model of the adapter.
module tb_guvm_modport;

    localparam int unsigned MW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_in = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_gnt, instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0, data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic [31:0] wdata, waddr;
    logic [3:0]  wbe;
    logic        wdata_valid;
    logic [31:0] boot_addr;
    logic [3:0]  core_id;
    logic [5:0]  cluster_id;
    logic        clock_en, test_en, irq, debug_req, fetch_enable;

    guvm_modport #(.INSTR_RDATA_WIDTH(32), .BOOT_ADDR(32'h0000000A), .MEM_WORDS(MW)) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_in_i(inst_in), .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .wdata_o(wdata), .waddr_o(waddr), .wbe_o(wbe), .wdata_valid_o(wdata_valid),
        .boot_addr_o(boot_addr), .core_id_o(core_id), .cluster_id_o(cluster_id),
        .clock_en_o(clock_en), .test_en_o(test_en), .irq_o(irq), .debug_req_o(debug_req),
        .fetch_enable_o(fetch_enable)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] w; } fexp_t;
    typedef struct { int cyc; bit ld; logic [31:0] v; } dexp_t;
    typedef struct { int cyc; logic [31:0] w; logic [31:0] a; logic [3:0] be; } sexp_t;

    fexp_t       fq[$];
    dexp_t       dq[$];
    sexp_t       sq[$];
    logic [31:0] hq[$];
    logic [31:0] mem_m [MW];
    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_w = '0, last_a = '0;
    logic [3:0]  last_be = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle, check the combinational handshakes, and queue the expected responses
    task automatic step(input logic r, input logic iv, input logic [31:0] iw, input logic ireq,
                        input logic dreq, input logic dwe, input logic [3:0] be,
                        input logic [31:0] da, input logic [31:0] dw);
        logic       gnt_e, rdy_e;
        logic [7:0] idx;
        @(posedge clk);
        #1;
        rst = r; inst_valid = iv; inst_in = iw; instr_req = ireq; instr_addr = $urandom;
        data_req = dreq; data_we = dwe; data_be = be; data_addr = da; data_wdata = dw;
        #1;
        gnt_e = ireq && (hq.size() != 0);
        rdy_e = (hq.size() == 0) || gnt_e;
        check1("instr_gnt", instr_gnt, gnt_e);
        check1("inst_ready", inst_ready, rdy_e);
        check1("data_gnt", data_gnt, dreq);
        if (r) begin
            hq.delete();
            foreach (mem_m[i]) mem_m[i] = '0;
        end else begin
            if (gnt_e) fq.push_back('{cyc, hq.pop_front()});
            if (iv && rdy_e) hq.push_back(iw);
            if (dreq) begin
                idx = da[9:2];
                dq.push_back('{cyc, !dwe, mem_m[idx]});
                if (dwe) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem_m[idx][8*b +: 8] = dw[8*b +: 8];
                    sq.push_back('{cyc, dw, da, be});
                end
            end
        end
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response
    always @(negedge clk) begin
        logic ev;
        fexp_t f;
        dexp_t d;
        sexp_t s;
        if (rst_q) begin
            check1("rst_instr_rvalid", instr_rvalid, 1'b0);
            check32("rst_instr_rdata", instr_rdata, 32'h0);
            check1("rst_data_rvalid", data_rvalid, 1'b0);
            check32("rst_data_rdata", data_rdata, 32'h0);
            check32("rst_wdata", wdata, 32'h0);
            check32("rst_waddr", waddr, 32'h0);
            check32("rst_wbe", 32'(wbe), 32'h0);
            check1("rst_wdata_valid", wdata_valid, 1'b0);
            check1("rst_fetch_enable", fetch_enable, 1'b0);
            last_w = '0; last_a = '0; last_be = '0;
        end else begin
            check1("fetch_enable", fetch_enable, 1'b1);

            while (fq.size() != 0 && fq[0].cyc + 1 < cyc) void'(fq.pop_front());
            ev = (fq.size() != 0) && (fq[0].cyc + 1 == cyc);
            check1("instr_rvalid", instr_rvalid, ev);
            if (ev) begin
                f = fq.pop_front();
                if (instr_rvalid) check32("instr_rdata", instr_rdata, f.w);
            end

            while (dq.size() != 0 && dq[0].cyc + 1 < cyc) void'(dq.pop_front());
            ev = (dq.size() != 0) && (dq[0].cyc + 1 == cyc);
            check1("data_rvalid", data_rvalid, ev);
            if (ev) begin
                d = dq.pop_front();
                if (data_rvalid && d.ld) check32("load_data", data_rdata, d.v);
            end

            while (sq.size() != 0 && sq[0].cyc + 1 < cyc) void'(sq.pop_front());
            ev = (sq.size() != 0) && (sq[0].cyc + 1 == cyc);
            check1("wdata_valid", wdata_valid, ev);
            if (ev) begin
                s = sq.pop_front();
                last_w = s.w; last_a = s.a; last_be = s.be;
            end
            check32("wdata", wdata, last_w);
            check32("waddr", waddr, last_a);
            check32("wbe", 32'(wbe), 32'(last_be));
        end
    end

    initial begin
        logic [31:0] a;
        logic        r;
        logic        we;
        foreach (mem_m[i]) mem_m[i] = '0;

        for (int i = 0; i < 10; i++) idle(1'b1);
        idle(1'b0);

        check32("boot_addr", boot_addr, 32'h0000000A);
        check32("core_id", 32'(core_id), 32'h0);
        check32("cluster_id", 32'(cluster_id), 32'h0);
        check1("clock_en", clock_en, 1'b1);
        check1("test_en", test_en, 1'b0);
        check1("irq", irq, 1'b0);
        check1("debug_req", debug_req, 1'b0);

        // Driver word while the core is already requesting
        step(1'b0, 1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(1'b0);

        // Core stalls on an empty holding register
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(1'b0);

        // Full store, load-after-store, byte-lane store
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0001, 32'h10, 32'h000000AA);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0);
        idle(1'b0);

        // Grant and reload every cycle
        step(1'b0, 1'b1, 32'hA0000000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 32'hA0000000 + 32'(i), 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(1'b0);

        // Randomized traffic with aliased addresses and occasional mid-traffic reset
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 149) == 0);
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            step(r, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), we, 4'($urandom), a, $urandom);
        end

        for (int i = 0; i < 3; i++) idle(1'b0);
        @(negedge clk);
        #1;
        check32("fetch_drain", 32'(fq.size()), 32'h0);
        check32("data_drain", 32'(dq.size()), 32'h0);
        check32("store_drain", 32'(sq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
